// File: rtl/barrel_shifter_pkg.sv
// +----------------------------------------------------------------------+
// | barrel_shifter_pkg : shift-mode encoding shared by the shifter pipe   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package barrel_shifter_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t SH_SLL = 2'd0;
  localparam shift_mode_t SH_SRL = 2'd1;
  localparam shift_mode_t SH_SRA = 2'd2;
  localparam shift_mode_t SH_ROR = 2'd3;

endpackage

`default_nettype wire

// File: rtl/barrel_shifter_pipe_if.sv
// +----------------------------------------------------------------------+
// | barrel_shifter_pipe_if : valid/ready operand and result streams      |
// | out_carry exists only with BARREL_SHIFTER_PIPE_CARRY_EN defined      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface barrel_shifter_pipe_if
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) ();

  localparam int SHW = $clog2(WIDTH);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [SHW-1:0]    in_amt;
  shift_mode_t       in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  logic              out_carry;
`endif

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    output out_carry,
`endif
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    input  out_carry,
`endif
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

`default_nettype wire

// File: rtl/barrel_shift_stage.sv
// +----------------------------------------------------------------------+
// | barrel_shift_stage : conditional 2^K shift plus one register slice   |
// | Carry slice present only with BARREL_SHIFTER_PIPE_CARRY_EN defined   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int SHW   = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  input  logic             carry_i,
  output logic             carry_o,
`endif
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  shift_mode_t      mode_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             sign_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output shift_mode_t      mode_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             sign_o
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   amt_d, amt_q;
  shift_mode_t      mode_d, mode_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             sign_d, sign_q;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  logic             carry_new;
  logic             carry_d, carry_q;
`endif

  // The last bit shifted out by the most recent active stage is the final carry.
  always_comb begin
    shifted = data_i;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    carry_new = carry_i;
`endif
    if (amt_i[K]) begin
      case (mode_i)
        SH_SLL: begin
          shifted = data_i << S;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
          carry_new = data_i[WIDTH-S];
`endif
        end
        SH_SRL: begin
          shifted = data_i >> S;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
          carry_new = data_i[S-1];
`endif
        end
        SH_SRA: begin
          shifted = (data_i >> S) | ({WIDTH{sign_i}} << (WIDTH - S));
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
          carry_new = data_i[S-1];
`endif
        end
        default: begin
          shifted = (data_i >> S) | (data_i << (WIDTH - S));
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
          carry_new = data_i[S-1];
`endif
        end
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    sign_d  = sign_q;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    carry_d = carry_q;
`endif
    if (adv) begin
      valid_d = valid_i;
      data_d  = shifted;
      amt_d   = amt_i;
      mode_d  = mode_i;
      tag_d   = tag_i;
      sign_d  = sign_i;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      carry_d = carry_new;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= SH_SLL;
      tag_q   <= '0;
      sign_q  <= 1'b0;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      sign_q  <= sign_d;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;
  assign tag_o   = tag_q;
  assign sign_o  = sign_q;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  assign carry_o = carry_q;
`endif

endmodule

`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
// +----------------------------------------------------------------------+
// | barrel_shifter_pipe : log2(WIDTH)-stage pipelined barrel shifter     |
// | Optional carry output: define BARREL_SHIFTER_PIPE_CARRY_EN           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  barrel_shifter_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic                        adv;
  logic [SHW:0]                valid_p;
  logic [SHW:0][WIDTH-1:0]     data_p;
  logic [SHW:0][SHW-1:0]       amt_p;
  shift_mode_t [SHW:0]         mode_p;
  logic [SHW:0][TAG_W-1:0]     tag_p;
  logic [SHW:0]                sign_p;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  logic [SHW:0]                carry_p;
`endif

  // Whole pipe advances together; only the last stage can block it.
  assign adv          = !valid_p[SHW] || bus.out_ready;
  assign bus.in_ready = adv;

  assign valid_p[0] = bus.in_valid;
  assign data_p[0]  = bus.in_data;
  assign amt_p[0]   = bus.in_amt;
  assign mode_p[0]  = bus.in_mode;
  assign tag_p[0]   = bus.in_tag;
  assign sign_p[0]  = bus.in_data[WIDTH-1];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  assign carry_p[0] = 1'b0;
`endif

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      barrel_shift_stage #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .SHW   (SHW),
        .K     (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (adv),
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
        .carry_i (carry_p[k]),
        .carry_o (carry_p[k+1]),
`endif
        .valid_i (valid_p[k]),
        .data_i  (data_p[k]),
        .amt_i   (amt_p[k]),
        .mode_i  (mode_p[k]),
        .tag_i   (tag_p[k]),
        .sign_i  (sign_p[k]),
        .valid_o (valid_p[k+1]),
        .data_o  (data_p[k+1]),
        .amt_o   (amt_p[k+1]),
        .mode_o  (mode_p[k+1]),
        .tag_o   (tag_p[k+1]),
        .sign_o  (sign_p[k+1])
      );
    end
  endgenerate

  assign bus.out_valid = valid_p[SHW];
  assign bus.out_data  = data_p[SHW];
  assign bus.out_tag   = tag_p[SHW];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
  assign bus.out_carry = carry_p[SHW];
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// +----------------------------------------------------------------------+
// | tb_barrel_shifter_pipe : directed self-checking bench, WIDTH = 16    |
// | Carry checks active when BARREL_SHIFTER_PIPE_CARRY_EN is defined     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_barrel_shifter_pipe;
  import barrel_shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int SHW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  barrel_shifter_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  barrel_shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic chk_carry(input string name, input logic exp);
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
    chk(name, {31'd0, bus.out_carry}, {31'd0, exp});
`endif
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a,
                       input shift_mode_t m, input logic [3:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  // One isolated operation: latency counted in edges after the accepting edge.
  task automatic single(input string name, input logic [15:0] d, input logic [3:0] a,
                        input shift_mode_t m, input logic [3:0] t,
                        input logic [15:0] exp_d, input logic exp_c);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(1'b1, d, a, m, t);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 4'h0, SH_SLL, 4'h0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_lat"}, lat, SHW - 1);
    chk({name, "_data"}, {16'd0, bus.out_data}, {16'd0, exp_d});
    chk({name, "_tag"}, {28'd0, bus.out_tag}, {28'd0, t});
    chk_carry({name, "_carry"}, exp_c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got;
    logic [15:0] held_d, exp16;
    logic [3:0]  held_t, amt;
    logic        held;

    drive(1'b0, 16'h0, 4'h0, SH_SLL, 4'h0);
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_tag", {28'd0, bus.out_tag}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_carry("rst_carry", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    single("sll6",   16'hA861, 4'd6,  SH_SLL, 4'd1, 16'h1840, 1'b0);
    single("srl1",   16'hFFFF, 4'd1,  SH_SRL, 4'd2, 16'h7FFF, 1'b1);
    single("sra15",  16'h8000, 4'd15, SH_SRA, 4'd3, 16'hFFFF, 1'b0);
    single("srl15",  16'h8000, 4'd15, SH_SRL, 4'd4, 16'h0001, 1'b0);
    single("ror15",  16'h0001, 4'd15, SH_ROR, 4'd5, 16'h0002, 1'b0);
    single("ror6z",  16'h0000, 4'd6,  SH_ROR, 4'd6, 16'h0000, 1'b0);
    single("ror1",   16'h8001, 4'd1,  SH_ROR, 4'd7, 16'hC000, 1'b1);
    single("sll4",   16'h1234, 4'd4,  SH_SLL, 4'd8, 16'h2340, 1'b1);
    single("sra4",   16'hF00F, 4'd4,  SH_SRA, 4'd9, 16'hFF00, 1'b1);
    single("sra4p",  16'h7F0F, 4'd4,  SH_SRA, 4'hA, 16'h07F0, 1'b1);
    single("amt0_sll", 16'h5A5A, 4'd0, SH_SLL, 4'hB, 16'h5A5A, 1'b0);
    single("amt0_srl", 16'h5A5A, 4'd0, SH_SRL, 4'hC, 16'h5A5A, 1'b0);
    single("amt0_sra", 16'h5A5A, 4'd0, SH_SRA, 4'hD, 16'h5A5A, 1'b0);
    single("amt0_ror", 16'h5A5A, 4'd0, SH_ROR, 4'hE, 16'h5A5A, 1'b0);

    // Back-to-back stream: result i is visible at the negedge four cycles later.
    @(negedge clk);
    for (int c = 0; c < 21; c++) begin
      if (c >= 4 && c < 20) begin
        chk("strm_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("strm_tag", {28'd0, bus.out_tag}, c - 4);
        chk("strm_data", {16'd0, bus.out_data}, 32'h0000FFFF >> (c - 4));
        chk_carry("strm_carry", (c - 4) != 0);
      end
      if (c < 16) begin
        chk("strm_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, 16'hFFFF, c[3:0], SH_SRL, c[3:0]);
      end else begin
        drive(1'b0, 16'h0, 4'h0, SH_SLL, 4'h0);
      end
      @(negedge clk);
    end

    // Backpressure: out_ready low for 5 cycles while ops keep arriving.
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_d = '0;
    held_t = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      bus.out_ready = !(c >= 5 && c < 10);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (held) begin
          chk("bp_hold_data", {16'd0, bus.out_data}, {16'd0, held_d});
          chk("bp_hold_tag", {28'd0, bus.out_tag}, {28'd0, held_t});
        end
        held   = 1'b1;
        held_d = bus.out_data;
        held_t = bus.out_tag;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        amt   = 4'(2 * got + 1);
        exp16 = 16'hFFFF << (15 - amt);
        chk("bp_tag", {28'd0, bus.out_tag}, got);
        chk("bp_data", {16'd0, bus.out_data}, {16'd0, exp16});
        chk_carry("bp_carry", amt == 4'd1);
        got++;
      end
      if (bus.in_ready && sent < 8) begin
        drive(1'b1, 16'h8001, 4'(2 * sent + 1), SH_SRA, sent[3:0]);
        sent++;
      end else begin
        drive(1'b0, 16'h0, 4'h0, SH_SLL, 4'h0);
      end
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 4'h0, SH_SLL, 4'h0);
    chk("bp_count", got, 32'd8);
    #1;
    chk("bp_no_dup", {31'd0, bus.out_valid}, 32'd0);

    // Reset with three operations in flight, first one already at the output.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1234, 4'd4, SH_SLL, 4'd1);
    @(negedge clk);
    drive(1'b1, 16'hFFFF, 4'd2, SH_SRL, 4'd2);
    @(negedge clk);
    drive(1'b1, 16'h8000, 4'd3, SH_SRA, 4'd3);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, SH_SLL, 4'h0);
    @(posedge clk);
    #1;
    chk("rst2_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rst2_pre_data", {16'd0, bus.out_data}, 32'h2340);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst2_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst2_tag", {28'd0, bus.out_tag}, 32'd0);
    chk_carry("rst2_carry", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst2_ready", {31'd0, bus.in_ready}, 32'd1);
    single("post_rst", 16'h00F0, 4'd4, SH_ROR, 4'd9, 16'h000F, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
